// File: rtl/shifter_pkg.sv
// Shared types and sizing for the datapath barrel shifter.
package shifter_pkg;

    localparam int WIDTH = 16;
    localparam int SHW   = $clog2(WIDTH);

    typedef enum logic {
        SH_SRA = 1'b0,
        SH_SLL = 1'b1
    } shift_mode_e;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/shifter_core.sv
// Combinational log-stage shift network: stage k moves the word by 2^k
// when shift_val[k] is set, in the direction chosen by mode.
module shifter_core
    import shifter_pkg::*;
(
    input  word_t            shift_in,
    input  logic [SHW-1:0]   shift_val,
    input  shift_mode_e      mode,
    output word_t            r
);

    // stg[0] is the operand, stg[SHW] the final result
    word_t stg [0:SHW];
    logic  sign;

    // SRA fill comes from the original operand's MSB; every right stage
    // preserves it, so taking it once up front is equivalent and shorter.
    assign sign   = shift_in[WIDTH-1];
    assign stg[0] = shift_in;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int S = 1 << k;
        word_t sll_w;
        word_t sra_w;

        // fixed-distance shifts are pure wiring; the mux is the only logic
        assign sll_w      = {stg[k][WIDTH-1-S:0], {S{1'b0}}};
        assign sra_w      = {{S{sign}}, stg[k][WIDTH-1:S]};
        assign stg[k+1]   = !shift_val[k]     ? stg[k] :
                            (mode == SH_SLL)  ? sll_w  : sra_w;
    end

    assign r = stg[SHW];

endmodule

// File: rtl/barrel_shifter.sv
// 16-bit SLL/SRA barrel shifter with a single enabled output register
// (fixed 1-cycle latency).
module barrel_shifter
    import shifter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              En,
    input  logic [WIDTH-1:0]  Shift_In,
    input  logic [SHW-1:0]    Shift_Val,
    input  logic              Mode,
    output logic [WIDTH-1:0]  Shift_Out
);

    // the stage network relies on every shift amount fitting in SHW bits
    if ((1 << SHW) != WIDTH) begin : g_width_check
        $error("barrel_shifter: WIDTH must be a power of two");
    end

    word_t r;

    shifter_core u_core (
        .shift_in  (Shift_In),
        .shift_val (Shift_Val),
        .mode      (shift_mode_e'(Mode)),
        .r         (r)
    );

    // output register: async clear dominates, En gates the load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Shift_Out <= '0;
        else if (En)
            Shift_Out <= r;
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter against an arithmetic reference.
module tb_barrel_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        En;
    logic        Mode;
    logic [15:0] Shift_In;
    logic [3:0]  Shift_Val;
    logic [15:0] Shift_Out;

    int checks   = 0;
    int failures = 0;

    barrel_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .En        (En),
        .Shift_In  (Shift_In),
        .Shift_Val (Shift_Val),
        .Mode      (Mode),
        .Shift_Out (Shift_Out)
    );

    always #5 clk = ~clk;

    // reference: SLL is multiply by 2^n mod 2^16; SRA is floor division
    // of the two's-complement value by 2^n
    function automatic logic [15:0] model(input logic [15:0] d, input int n, input logic m);
        longint p;
        longint s;
        p = longint'(2) ** n;
        if (m)
            return 16'((longint'(d) * p) % 65536);
        s = d[15] ? longint'(d) - 65536 : longint'(d);
        if (s >= 0) s = s / p;
        else        s = -((-s + p - 1) / p);
        return 16'(s & 65535);
    endfunction

    // inputs change on the falling edge, away from the sampling edge
    task automatic drive(input logic [15:0] d, input logic [3:0] v, input logic m, input logic e);
        @(negedge clk);
        Shift_In  = d;
        Shift_Val = v;
        Mode      = m;
        En        = e;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(16'hABCD, 4'd3, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (Shift_Out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_held got=%h exp=%h", Shift_Out, 16'h0000);
        end
        rst_n = 1'b1;
        drive(16'h1234, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (Shift_Out !== 16'h1234) begin
            failures++;
            $display("FAIL reset_release_load got=%h exp=%h", Shift_Out, 16'h1234);
        end
        // asynchronous clear mid-cycle, well before the next rising edge
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (Shift_Out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", Shift_Out, 16'h0000);
        end
        // reset beats En=1 across an edge
        @(negedge clk);
        checks++;
        if (Shift_Out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_wins got=%h exp=%h", Shift_Out, 16'h0000);
        end
        rst_n = 1'b1;
        drive(16'h00FF, 4'd4, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (Shift_Out !== 16'h0FF0) begin
            failures++;
            $display("FAIL reset_rerelease got=%h exp=%h", Shift_Out, 16'h0FF0);
        end
    endtask

    task automatic test_basic;
        drive(16'h8001, 4'd1, 1'b0, 1'b1);
        #1;
        checks++;
        if (Shift_Out !== 16'h0FF0) begin
            failures++;
            $display("FAIL latency_not_early got=%h exp=%h", Shift_Out, 16'h0FF0);
        end
        @(negedge clk);
        checks++;
        if (Shift_Out !== 16'hC000) begin
            failures++;
            $display("FAIL basic_sra got=%h exp=%h", Shift_Out, 16'hC000);
        end
        drive(16'h8001, 4'd1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (Shift_Out !== 16'h0002) begin
            failures++;
            $display("FAIL basic_sll got=%h exp=%h", Shift_Out, 16'h0002);
        end
    endtask

    task automatic test_boundary;
        logic [15:0] din [6]  = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234, 16'h1234, 16'h0001};
        logic [3:0]  val [6]  = '{4'd15,    4'd15,    4'd15,    4'd0,     4'd0,     4'd15};
        logic        md  [6]  = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        logic [15:0] exp [6]  = '{16'hFFFF, 16'h0000, 16'h8000, 16'h1234, 16'h1234, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            drive(din[i], val[i], md[i], 1'b1);
            @(negedge clk);
            checks++;
            if (Shift_Out !== exp[i]) begin
                failures++;
                $display("FAIL boundary_%0d in=%h val=%0d mode=%b got=%h exp=%h",
                         i, din[i], val[i], md[i], Shift_Out, exp[i]);
            end
        end
    endtask

    task automatic test_hold;
        drive(16'h00F0, 4'd4, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (Shift_Out !== 16'h0F00) begin
            failures++;
            $display("FAIL hold_load got=%h exp=%h", Shift_Out, 16'h0F00);
        end
        for (int i = 0; i < 3; i++) begin
            Shift_In  = 16'($urandom);
            Shift_Val = 4'($urandom);
            Mode      = 1'($urandom);
            En        = 1'b0;
            @(negedge clk);
            checks++;
            if (Shift_Out !== 16'h0F00) begin
                failures++;
                $display("FAIL hold_cycle%0d got=%h exp=%h", i, Shift_Out, 16'h0F00);
            end
        end
    endtask

    // every shift amount and direction over a handful of operands
    task automatic test_sweep;
        logic [15:0] pats [7] = '{16'h8001, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234, 16'hA5A5, 16'h0000};
        logic [15:0] exp;
        pats[6] = 16'($urandom);
        for (int p = 0; p < 7; p++)
            for (int v = 0; v < 16; v++)
                for (int m = 0; m < 2; m++) begin
                    drive(pats[p], 4'(v), 1'(m), 1'b1);
                    exp = model(pats[p], v, 1'(m));
                    @(negedge clk);
                    checks++;
                    if (Shift_Out !== exp) begin
                        failures++;
                        $display("FAIL sweep in=%h val=%0d mode=%0d got=%h exp=%h",
                                 pats[p], v, m, Shift_Out, exp);
                    end
                end
    endtask

    // new operands every cycle with random enables and occasional resets
    task automatic test_back_to_back;
        logic [15:0] exp;
        logic [15:0] d;
        logic [3:0]  v;
        logic        m;
        logic        e;
        drive(16'h0000, 4'd0, 1'b1, 1'b1);
        exp = 16'h0000;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            checks++;
            if (Shift_Out !== exp) begin
                failures++;
                $display("FAIL b2b cycle=%0d got=%h exp=%h", i, Shift_Out, exp);
            end
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (Shift_Out !== 16'h0000) begin
                    failures++;
                    $display("FAIL b2b_reset cycle=%0d got=%h exp=%h", i, Shift_Out, 16'h0000);
                end
                exp   = 16'h0000;
                rst_n = 1'b1;
            end
            d = 16'($urandom);
            v = 4'($urandom);
            m = 1'($urandom);
            e = ($urandom_range(0, 3) != 0);
            Shift_In  = d;
            Shift_Val = v;
            Mode      = m;
            En        = e;
            if (e) exp = model(d, int'(v), m);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        En        = 1'b0;
        Mode      = 1'b0;
        Shift_In  = '0;
        Shift_Val = '0;
        #1;
        checks++;
        if (Shift_Out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_initial got=%h exp=%h", Shift_Out, 16'h0000);
        end
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_sweep();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
